// File: rtl/tx_frame_drain.sv
// Drains tagged camera words from an FWFT FIFO onto the MAC transmit client.
// Pads short frames, truncates long ones, flags underruns and enforces an IFG.
module tx_frame_drain #(
    parameter int DATA_W       = 8,
    parameter int COUNT_W      = 16,
    parameter int READY_THRESH = 20,
    parameter int MIN_FRAME    = 60,
    parameter int MAX_FRAME    = 1514,
    parameter int IFG_CYCLES   = 12
) (
    input  logic               tx_clk,
    input  logic               reset_b,
    input  logic [DATA_W:0]    fifo_dout,
    input  logic               fifo_empty,
    input  logic [COUNT_W-1:0] fifo_rd_count,
    output logic               fifo_rd_en,
    output logic [DATA_W-1:0]  tx_data,
    output logic               tx_data_valid,
    input  logic               tx_ack,
    output logic               tx_underrun,
    output logic               busy,
    output logic [15:0]        frames_sent,
    output logic               underrun_err,
    output logic               trunc_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        STREAM,
        PAD,
        FLUSH,
        IFG
    } state_t;

    localparam logic [15:0]        MIN_B    = 16'(MIN_FRAME);
    localparam logic [15:0]        MAX_B    = 16'(MAX_FRAME);
    localparam logic [15:0]        IFG_LAST = 16'(IFG_CYCLES - 1);
    localparam logic [COUNT_W-1:0] THRESH   = COUNT_W'(READY_THRESH);

    state_t            state, state_n;
    logic [15:0]       byte_cnt, byte_cnt_n;
    logic [15:0]       ifg_cnt, ifg_cnt_n;
    logic              rd, valid, under, sent_inc, trunc_set;
    logic [DATA_W-1:0] data;

    logic              tag;
    logic [DATA_W-1:0] head;

    assign tag  = fifo_dout[DATA_W];
    assign head = fifo_dout[DATA_W-1:0];

    always_ff @(posedge tx_clk or negedge reset_b) begin
        if (!reset_b) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            ifg_cnt      <= '0;
            frames_sent  <= '0;
            underrun_err <= 1'b0;
            trunc_err    <= 1'b0;
        end else begin
            state    <= state_n;
            byte_cnt <= byte_cnt_n;
            ifg_cnt  <= ifg_cnt_n;
            if (sent_inc)
                frames_sent <= frames_sent + 16'd1;
            if (under)
                underrun_err <= 1'b1;
            if (trunc_set)
                trunc_err <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        ifg_cnt_n  = '0;
        rd         = 1'b0;
        valid      = 1'b0;
        data       = '0;
        under      = 1'b0;
        sent_inc   = 1'b0;
        trunc_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && !tag)
                    rd = 1'b1;
                else if (!fifo_empty && tag && fifo_rd_count > THRESH)
                    state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                valid = 1'b1;
                data  = head;
                if (tx_ack && !fifo_empty) begin
                    rd         = 1'b1;
                    byte_cnt_n = 16'd1;
                    state_n    = STREAM;
                end
            end
            STREAM: begin
                if (fifo_empty) begin
                    under   = 1'b1;
                    state_n = FLUSH;
                end else if (tag && byte_cnt == MAX_B) begin
                    trunc_set = 1'b1;
                    state_n   = FLUSH;
                end else if (tag) begin
                    valid      = 1'b1;
                    data       = head;
                    rd         = 1'b1;
                    byte_cnt_n = byte_cnt + 16'd1;
                end else if (byte_cnt < MIN_B) begin
                    // delimiter arrived early: its slot becomes the first pad byte
                    valid      = 1'b1;
                    rd         = 1'b1;
                    byte_cnt_n = byte_cnt + 16'd1;
                    state_n    = PAD;
                end else begin
                    rd       = 1'b1;
                    sent_inc = 1'b1;
                    state_n  = IFG;
                end
            end
            PAD: begin
                if (byte_cnt < MIN_B) begin
                    valid      = 1'b1;
                    byte_cnt_n = byte_cnt + 16'd1;
                end else begin
                    sent_inc = 1'b1;
                    state_n  = IFG;
                end
            end
            FLUSH: begin
                if (!fifo_empty) begin
                    rd = 1'b1;
                    if (!tag)
                        state_n = IFG;
                end
            end
            IFG: begin
                byte_cnt_n = '0;
                if (ifg_cnt == IFG_LAST)
                    state_n = IDLE;
                else
                    ifg_cnt_n = ifg_cnt + 16'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // IDLE may pop delimiters, so the pop is masked while reset is held
    assign fifo_rd_en    = rd && reset_b;
    assign tx_data_valid = valid;
    assign tx_data       = data;
    assign tx_underrun   = under;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_tx_frame_drain.sv
// Randomised scoreboard bench for tx_frame_drain with an FWFT FIFO model
// and a frame-level reference model.
module tb_tx_frame_drain;

    localparam int MIN_FRAME  = 60;
    localparam int MAX_FRAME  = 1514;
    localparam int IFG_CYCLES = 12;
    localparam int BIG        = 1 << 30;

    logic        tx_clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [8:0]  fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_rd_count = '0;
    logic        fifo_rd_en;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_ack = 1'b0;
    logic        tx_underrun;
    logic        busy;
    logic [15:0] frames_sent;
    logic        underrun_err;
    logic        trunc_err;

    always #5 tx_clk = ~tx_clk;

    tx_frame_drain #(
        .DATA_W(8), .COUNT_W(16), .READY_THRESH(20),
        .MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME),
        .IFG_CYCLES(IFG_CYCLES)
    ) dut (
        .tx_clk(tx_clk), .reset_b(reset_b),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_ack(tx_ack), .tx_underrun(tx_underrun), .busy(busy),
        .frames_sent(frames_sent), .underrun_err(underrun_err),
        .trunc_err(trunc_err)
    );

    typedef struct {
        int len;
        int gap;
    } frame_t;

    logic [8:0] fq[$], wq[$], hold_q[$];
    logic [7:0] exp_q[$];
    frame_t     fr_q[$];
    frame_t     mf;

    int checks = 0, errors = 0;
    int frames_m = 0, pulses_m = 0;
    bit trunc_m = 0, under_m = 0;
    int ack_delay = 3, pend = 0, got = 0, low_cnt = 0, un_seen = 0;
    bit in_frame = 0, have_prev = 0, prev_valid = 0, prev_un = 0;
    bit rd_s = 0, mon_en = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // FWFT FIFO model plus MAC ack generator
    always @(posedge tx_clk) begin
        #1;
        if (rd_s && fq.size() > 0)
            void'(fq.pop_front());
        while (wq.size() > 0)
            fq.push_back(wq.pop_front());
        fifo_empty    = (fq.size() == 0);
        fifo_dout     = fifo_empty ? 9'h000 : fq[0];
        fifo_rd_count = 16'(fq.size());
        tx_ack        = (pend == ack_delay);
    end

    // Monitor: pops expected bytes and frame records as the DUT presents them
    always @(negedge tx_clk) begin
        rd_s = fifo_rd_en;
        if (mon_en) begin
            if (fifo_rd_en && fifo_empty) begin
                errors++;
                $display("FAIL rd_when_empty: got 1 expected 0 at %0t", $time);
            end
            if (tx_underrun) begin
                un_seen++;
                if (prev_un)
                    check("underrun_pulse_width", 2, 1);
            end
            prev_un = tx_underrun;
            if (tx_data_valid) begin
                if (!prev_valid && have_prev && fr_q.size() > 0) begin
                    if (fr_q[0].gap >= 0)
                        check("ifg_exact", low_cnt, fr_q[0].gap);
                    else
                        check("ifg_min_ok", int'(low_cnt >= 1 + IFG_CYCLES), 1);
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 1, 0);
                end else if (!in_frame) begin
                    check("hold_byte", tx_data, exp_q[0]);
                    if (tx_ack) begin
                        void'(exp_q.pop_front());
                        in_frame = 1;
                        got      = 1;
                        pend     = 0;
                    end else begin
                        pend++;
                    end
                end else begin
                    check("data", tx_data, exp_q.pop_front());
                    got++;
                end
            end else if (in_frame) begin
                in_frame  = 0;
                have_prev = 1;
                low_cnt   = 1;
                if (fr_q.size() > 0) begin
                    mf = fr_q.pop_front();
                    check("frame_len", got, mf.len);
                end else begin
                    check("unexpected_frame", 1, 0);
                end
            end else begin
                low_cnt++;
            end
            prev_valid = tx_data_valid;
        end
    end

    // Reference model: expected bytes are derived from the frame's rules
    task automatic issue(input int n, input bit underrun, input int fill,
                         input int gap, input bit seq, input int stage);
        logic [8:0] w[$];
        logic [7:0] d;
        frame_t     f;
        for (int i = 0; i < n; i++) begin
            d = seq ? 8'(i) : 8'($urandom);
            w.push_back({1'b1, d});
            if (i < MAX_FRAME)
                exp_q.push_back(d);
        end
        w.push_back({1'b0, 8'($urandom)});
        for (int i = 0; i < fill; i++)
            w.push_back({1'b0, 8'($urandom)});
        if (n > MAX_FRAME) begin
            f.len   = MAX_FRAME;
            trunc_m = 1;
        end else if (underrun) begin
            f.len   = n;
            under_m = 1;
            pulses_m++;
        end else if (n < MIN_FRAME) begin
            for (int i = n; i < MIN_FRAME; i++)
                exp_q.push_back(8'h00);
            f.len = MIN_FRAME;
            frames_m++;
        end else begin
            f.len = n;
            frames_m++;
        end
        f.gap = gap;
        fr_q.push_back(f);
        for (int i = 0; i < w.size(); i++) begin
            if (i < stage)
                wq.push_back(w[i]);
            else
                hold_q.push_back(w[i]);
        end
    endtask

    task automatic wait_until(input string name, input bit need_idle);
        int t = 0;
        @(negedge tx_clk);
        while (!(fq.size() == 0 && wq.size() == 0 && exp_q.size() == 0
                 && !in_frame && !tx_data_valid && (!need_idle || !busy))
               && t < 5000) begin
            @(negedge tx_clk);
            t++;
        end
        if (t >= 5000) begin
            errors++;
            $display("FAIL timeout_%s: got busy=%0d expected drained", name, busy);
        end
    endtask

    task automatic check_status(input string s);
        check({s, "_frames_sent"}, frames_sent, 16'(frames_m));
        check({s, "_trunc_err"}, trunc_err, trunc_m);
        check({s, "_underrun_err"}, underrun_err, under_m);
        check({s, "_underrun_pulses"}, un_seen, pulses_m);
    endtask

    initial begin
        int n, t;
        repeat (3) @(negedge tx_clk);
        check("rst_valid", tx_data_valid, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_frames", frames_sent, 0);
        check("rst_flags", {underrun_err, trunc_err, tx_underrun}, 0);
        check("rst_data", tx_data, 0);
        reset_b = 1'b1;
        mon_en  = 1;
        @(negedge tx_clk);

        // 100-byte frame, then a padded 10-byte frame queued back to back
        ack_delay = 3;
        issue(100, 0, 0, -1, 1, BIG);
        issue(10, 0, 20, 2 + IFG_CYCLES, 0, BIG);
        wait_until("normal_pad", 1);
        check_status("t12");

        // Oversized frame truncated, then a normal frame follows
        issue(1600, 0, 0, -1, 1, BIG);
        issue(30, 0, 0, -1, 0, BIG);
        wait_until("trunc", 1);
        check_status("t3");

        // FIFO runs dry mid-frame; delimiter arrives much later
        issue(25, 1, 0, -1, 0, 25);
        wait_until("underrun", 0);
        repeat (10) @(negedge tx_clk);
        check("flush_busy", busy, 1);
        check("flush_underrun_err", underrun_err, 1);
        while (hold_q.size() > 0)
            wq.push_back(hold_q.pop_front());
        wait_until("flush_exit", 1);
        check_status("t4");

        // Start threshold is strict: 20 words wait, the 21st releases
        issue(21, 0, 0, -1, 0, 20);
        repeat (5) @(negedge tx_clk);
        check("thresh20_busy", busy, 0);
        wq.push_back(hold_q.pop_front());
        @(negedge tx_clk);
        check("thresh21_prev_busy", busy, 0);
        @(negedge tx_clk);
        check("thresh21_busy", busy, 1);
        check("thresh21_valid", tx_data_valid, 1);
        while (hold_q.size() > 0)
            wq.push_back(hold_q.pop_front());
        wait_until("thresh", 1);
        check_status("t5");

        for (int k = 0; k < 12; k++) begin
            ack_delay = $urandom_range(1, 4);
            n = $urandom_range(1, 200);
            issue(n, 0, (n < 21) ? 21 - n : 0, -1, 0, BIG);
            wait_until("random", 1);
        end
        check_status("rand");

        // Reset in the middle of streaming
        ack_delay = 2;
        issue(80, 0, 0, -1, 1, BIG);
        t = 0;
        while (!(in_frame && got >= 20) && t < 1000) begin
            @(negedge tx_clk);
            t++;
        end
        check("pre_reset_streaming", tx_data_valid, 1);
        mon_en  = 0;
        reset_b = 1'b0;
        #1;
        check("mid_rst_valid", tx_data_valid, 0);
        check("mid_rst_rd_en", fifo_rd_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frames", frames_sent, 0);
        check("mid_rst_flags", {underrun_err, trunc_err, tx_underrun}, 0);
        fq.delete(); wq.delete(); hold_q.delete();
        exp_q.delete(); fr_q.delete();
        rd_s = 0; pend = 0; got = 0; in_frame = 0; have_prev = 0;
        prev_valid = 0; prev_un = 0; un_seen = 0; tx_ack = 1'b0;
        frames_m = 0; pulses_m = 0; trunc_m = 0; under_m = 0;
        repeat (3) @(negedge tx_clk);
        reset_b = 1'b1;
        mon_en  = 1;
        issue(40, 0, 0, -1, 0, BIG);
        wait_until("post_reset", 1);
        check_status("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
